// File: rtl/max3421e_spi_arbiter.sv
// Two-client SPI arbiter for the MAX3421E: round-robin grant, framing of each
// request as one 2-byte mode-0 SPI transaction (command, data), and return of
// the captured status/read bytes to the requesting client.
module max3421e_spi_arbiter #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        clk_in,
    input  logic        n_rst_in,
    input  logic [1:0]  req_valid_in,
    output logic [1:0]  req_ready_out,
    input  logic [1:0]  req_write_in,
    input  logic [9:0]  req_addr_in,
    input  logic [15:0] req_wdata_in,
    output logic [1:0]  resp_valid_out,
    output logic [7:0]  resp_rdata_out,
    output logic [7:0]  resp_status_out,
    output logic        busy_out,
    output logic        n_ss_out,
    output logic        sclk_out,
    output logic        mosi_out,
    input  logic        miso_in
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned BIT_W = 4;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [BIT_W-1:0] r_bit;
    logic [14:0]      r_tx;
    logic [15:0]      r_rx;
    logic             r_owner;
    logic             r_last_grant;
    logic             r_n_ss;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_busy;
    logic [1:0]       r_resp_valid;
    logic [7:0]       r_rdata;
    logic [7:0]       r_status;

    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_sel;
    logic [4:0]       w_addr;
    logic             w_write;
    logic [7:0]       w_wdata;
    logic [7:0]       w_cmd;
    logic [15:0]      w_word;
    logic             w_div_last;

    // Round-robin grant: a lone requester wins, a tie goes to the client not served last.
    always_comb begin
        w_grant = 2'b00;
        case (req_valid_in)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    // Ready is only offered while idle and out of reset, so at most one bit is ever set.
    assign req_ready_out = ((r_state == S_IDLE) && n_rst_in) ? w_grant : 2'b00;
    assign w_accept      = |req_ready_out;
    assign w_sel         = req_ready_out[1];

    assign w_addr  = w_sel ? req_addr_in[9:5] : req_addr_in[4:0];
    assign w_write = req_write_in[w_sel];
    assign w_wdata = w_sel ? req_wdata_in[15:8] : req_wdata_in[7:0];
    // ACKSTAT bit is always 0; reads shift a zero data byte.
    assign w_cmd   = {w_addr, 1'b0, w_write, 1'b0};
    assign w_word  = {w_cmd, (w_write ? w_wdata : 8'h00)};

    assign w_div_last = (r_div_cnt == DIV_LAST);

    // Transaction FSM with registered SPI pins and response outputs.
    always_ff @(posedge clk_in) begin
        if (!n_rst_in) begin
            r_state      <= S_IDLE;
            r_div_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_bit        <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_n_ss       <= 1'b1;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 2'b00;
            r_rdata      <= 8'h00;
            r_status     <= 8'h00;
        end else begin
            r_resp_valid <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_SETUP;
                        r_owner      <= w_sel;
                        r_last_grant <= w_sel;
                        r_tx         <= w_word[14:0];
                        r_mosi       <= w_word[15];
                        r_n_ss       <= 1'b0;
                        r_sclk       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_div_cnt    <= '0;
                    end
                end
                S_SETUP: begin
                    if (w_div_last) begin
                        r_div_cnt <= '0;
                        r_sclk    <= 1'b1;
                        r_bit     <= BIT_W'(15);
                        r_state   <= S_SHIFT;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (r_sclk) begin
                        // Capture MISO on the first cycle of each high phase.
                        if (r_div_cnt == '0) begin
                            r_rx <= {r_rx[14:0], miso_in};
                        end
                        if (w_div_last) begin
                            r_div_cnt <= '0;
                            r_sclk    <= 1'b0;
                            r_tx      <= {r_tx[13:0], 1'b0};
                            if (r_bit == '0) begin
                                r_mosi  <= 1'b0;
                                r_state <= S_HOLD;
                            end else begin
                                r_mosi  <= r_tx[14];
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + DIV_W'(1);
                        end
                    end else begin
                        if (w_div_last) begin
                            r_div_cnt <= '0;
                            r_sclk    <= 1'b1;
                            r_bit     <= r_bit - BIT_W'(1);
                        end else begin
                            r_div_cnt <= r_div_cnt + DIV_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (w_div_last) begin
                        r_div_cnt    <= '0;
                        r_state      <= S_GAP;
                        r_n_ss       <= 1'b1;
                        r_resp_valid <= r_owner ? 2'b10 : 2'b01;
                        r_rdata      <= r_rx[7:0];
                        r_status     <= r_rx[15:8];
                        r_gap_cnt    <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid_out  = r_resp_valid;
    assign resp_rdata_out  = r_rdata;
    assign resp_status_out = r_status;
    assign busy_out        = r_busy;
    assign n_ss_out        = r_n_ss;
    assign sclk_out        = r_sclk;
    assign mosi_out        = r_mosi;

endmodule

// File: tb/tb_max3421e_spi_arbiter.sv
// Bench for max3421e_spi_arbiter: vector table of single transactions plus
// hand-written sequences for arbitration, withdrawal, mid-frame reset and a
// fast-parameter instance.
module tb_max3421e_spi_arbiter;

    logic        clk_in = 1'b0;
    logic        n_rst_in = 1'b0;
    logic [1:0]  req_valid_in = 2'b00;
    logic [1:0]  req_write_in = 2'b00;
    logic [9:0]  req_addr_in = '0;
    logic [15:0] req_wdata_in = '0;
    logic [1:0]  req_ready_out;
    logic [1:0]  resp_valid_out;
    logic [7:0]  resp_rdata_out;
    logic [7:0]  resp_status_out;
    logic        busy_out;
    logic        n_ss_out;
    logic        sclk_out;
    logic        mosi_out;
    logic        miso_in = 1'b0;

    logic [1:0]  f_valid = 2'b00;
    logic [1:0]  f_ready;
    logic [1:0]  f_resp_valid;
    logic [7:0]  f_rdata;
    logic [7:0]  f_status;
    logic        f_busy;
    logic        f_n_ss;
    logic        f_sclk;
    logic        f_mosi;

    max3421e_spi_arbiter dut (
        .clk_in          (clk_in),
        .n_rst_in        (n_rst_in),
        .req_valid_in    (req_valid_in),
        .req_ready_out   (req_ready_out),
        .req_write_in    (req_write_in),
        .req_addr_in     (req_addr_in),
        .req_wdata_in    (req_wdata_in),
        .resp_valid_out  (resp_valid_out),
        .resp_rdata_out  (resp_rdata_out),
        .resp_status_out (resp_status_out),
        .busy_out        (busy_out),
        .n_ss_out        (n_ss_out),
        .sclk_out        (sclk_out),
        .mosi_out        (mosi_out),
        .miso_in         (miso_in)
    );

    max3421e_spi_arbiter #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_fast (
        .clk_in          (clk_in),
        .n_rst_in        (n_rst_in),
        .req_valid_in    (f_valid),
        .req_ready_out   (f_ready),
        .req_write_in    (2'b01),
        .req_addr_in     (10'h011),
        .req_wdata_in    (16'h0055),
        .resp_valid_out  (f_resp_valid),
        .resp_rdata_out  (f_rdata),
        .resp_status_out (f_status),
        .busy_out        (f_busy),
        .n_ss_out        (f_n_ss),
        .sclk_out        (f_sclk),
        .mosi_out        (f_mosi),
        .miso_in         (1'b0)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         client;
        bit         write;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [15:0] miso;
        logic [7:0] exp_cmd;
        logic [7:0] exp_data;
        logic [7:0] exp_status;
        logic [7:0] exp_rdata;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state for the default-parameter instance
    logic [15:0] miso_word = 16'h0000;
    logic [15:0] mosi_cap = '0;
    int rise_cnt = 0, low_run = 0, last_low = 0, high_run = 0, last_high = 0;
    int resp_cnt = 0, both_ready = 0, miso_idx = 15, cyc = 0;
    logic [1:0] last_resp = 2'b00;
    logic [7:0] last_status = 8'h00, last_rdata = 8'h00;
    logic prev_nss = 1'b1, prev_sclk = 1'b0;
    int glog [$];
    int gcyc [$];

    // Monitor state for the fast instance
    int ncyc = 0, f_low_run = 0, f_last_low = 0, f_rises = 0, f_last_rise = -1;
    int f_min_per = 1000, f_max_per = 0, f_resp_cnt = 0;
    logic f_prev_nss = 1'b1, f_prev_sclk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept log: which client was taken and on which cycle
    always @(posedge clk_in) begin
        if (n_rst_in && ((req_valid_in & req_ready_out) != 2'b00)) begin
            glog.push_back(int'(req_ready_out[1]));
            gcyc.push_back(cyc);
        end
        cyc++;
    end

    // SPI pin monitor and MAX3421E MISO model (shifts on SCLK falling edges)
    always @(negedge clk_in) begin
        if (n_ss_out === 1'b0) begin
            if (prev_nss) begin
                last_high = high_run;
                low_run   = 0;
                rise_cnt  = 0;
                mosi_cap  = '0;
                miso_idx  = 15;
                miso_in   = miso_word[15];
            end
            low_run++;
        end else begin
            if (!prev_nss) begin
                last_low = low_run;
                high_run = 0;
            end
            high_run++;
        end
        if (sclk_out && !prev_sclk && !n_ss_out) begin
            mosi_cap = {mosi_cap[14:0], mosi_out};
            rise_cnt++;
        end
        if (!sclk_out && prev_sclk && !n_ss_out) begin
            if (miso_idx > 0) miso_idx--;
            miso_in = miso_word[miso_idx];
        end
        if (resp_valid_out != 2'b00) begin
            resp_cnt++;
            last_resp   = resp_valid_out;
            last_status = resp_status_out;
            last_rdata  = resp_rdata_out;
        end
        if (req_ready_out == 2'b11) both_ready++;
        prev_nss  = (n_ss_out !== 1'b0);
        prev_sclk = (sclk_out === 1'b1);
    end

    // Fast-instance monitor: frame length and SCLK period
    always @(negedge clk_in) begin
        ncyc++;
        if (f_n_ss === 1'b0) begin
            if (f_prev_nss) begin
                f_low_run   = 0;
                f_rises     = 0;
                f_last_rise = -1;
            end
            f_low_run++;
        end else if (!f_prev_nss) begin
            f_last_low = f_low_run;
        end
        if (f_sclk && !f_prev_sclk && !f_n_ss) begin
            if (f_last_rise >= 0) begin
                if (ncyc - f_last_rise < f_min_per) f_min_per = ncyc - f_last_rise;
                if (ncyc - f_last_rise > f_max_per) f_max_per = ncyc - f_last_rise;
            end
            f_last_rise = ncyc;
            f_rises++;
        end
        if (f_resp_valid != 2'b00) f_resp_cnt++;
        f_prev_nss  = (f_n_ss !== 1'b0);
        f_prev_sclk = (f_sclk === 1'b1);
    end

    task automatic issue(input int c, input bit w, input logic [4:0] a, input logic [7:0] d,
                         output bit ok);
        @(negedge clk_in);
        req_write_in[c]       = w;
        req_addr_in[5*c +: 5] = a;
        req_wdata_in[8*c +: 8] = d;
        req_valid_in[c]       = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            #1;
            if (req_ready_out[c]) ok = 1'b1;
            @(negedge clk_in);
        end
        req_valid_in[c] = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk_in);
            if (resp_cnt >= target && !busy_out) ok = 1'b1;
        end
    endtask

    task automatic run_vec(input int i);
        bit ok;
        int r0, g0;
        miso_word = vecs[i].miso;
        r0 = resp_cnt;
        g0 = glog.size();
        issue(vecs[i].client, vecs[i].write, vecs[i].addr, vecs[i].wdata, ok);
        check($sformatf("v%0d accepted", i), 32'(ok), 1);
        wait_done(r0 + 1, ok);
        check($sformatf("v%0d completed", i), 32'(ok), 1);
        check($sformatf("v%0d owner", i), (glog.size() > g0) ? glog[g0] : -1, vecs[i].client);
        check($sformatf("v%0d mosi cmd", i), 32'(mosi_cap[15:8]), 32'(vecs[i].exp_cmd));
        check($sformatf("v%0d mosi data", i), 32'(mosi_cap[7:0]), 32'(vecs[i].exp_data));
        check($sformatf("v%0d sclk rises", i), rise_cnt, 16);
        check($sformatf("v%0d n_ss low cycles", i), last_low, 132);
        check($sformatf("v%0d resp count", i), resp_cnt - r0, 1);
        check($sformatf("v%0d resp_valid", i), 32'(last_resp), (vecs[i].client == 1) ? 2 : 1);
        check($sformatf("v%0d status", i), 32'(last_status), 32'(vecs[i].exp_status));
        check($sformatf("v%0d rdata", i), 32'(last_rdata), 32'(vecs[i].exp_rdata));
        check($sformatf("v%0d status held", i), 32'(resp_status_out), 32'(vecs[i].exp_status));
        check($sformatf("v%0d rdata held", i), 32'(resp_rdata_out), 32'(vecs[i].exp_rdata));
    endtask

    initial begin
        bit ok;
        int r0, g0;

        //          client wr  addr   wdata  miso      cmd    data   status rdata
        vecs[0] = '{0,     1, 5'h11, 8'h55, 16'h4C12, 8'h8A, 8'h55, 8'h4C, 8'h12};
        vecs[1] = '{1,     0, 5'h13, 8'hEE, 16'h09A5, 8'h98, 8'h00, 8'h09, 8'hA5};
        vecs[2] = '{0,     0, 5'h1F, 8'h00, 16'h3C7E, 8'hF8, 8'h00, 8'h3C, 8'h7E};
        vecs[3] = '{1,     1, 5'h00, 8'hFF, 16'h8001, 8'h02, 8'hFF, 8'h80, 8'h01};
        vecs[4] = '{0,     1, 5'h0A, 8'hC3, 16'hFFFF, 8'h52, 8'hC3, 8'hFF, 8'hFF};

        // Reset values, with both clients already requesting
        n_rst_in     = 1'b0;
        req_valid_in = 2'b11;
        repeat (3) @(negedge clk_in);
        check("reset n_ss", 32'(n_ss_out), 1);
        check("reset sclk", 32'(sclk_out), 0);
        check("reset mosi", 32'(mosi_out), 0);
        check("reset ready", 32'(req_ready_out), 0);
        check("reset resp_valid", 32'(resp_valid_out), 0);
        check("reset rdata", 32'(resp_rdata_out), 0);
        check("reset status", 32'(resp_status_out), 0);
        check("reset busy", 32'(busy_out), 0);

        // Both held valid from reset: grants alternate 0,1,0,1
        miso_word = 16'h0000;
        n_rst_in  = 1'b1;
        for (int k = 0; k < 1000 && glog.size() < 4; k++) @(negedge clk_in);
        req_valid_in = 2'b00;
        check("rr accepts", glog.size(), 4);
        wait_done(4, ok);
        check("rr completed", 32'(ok), 1);
        if (glog.size() >= 4) begin
            check("rr grant0", glog[0], 0);
            check("rr grant1", glog[1], 1);
            check("rr grant2", glog[2], 0);
            check("rr grant3", glog[3], 1);
            check("rr accept spacing a", gcyc[1] - gcyc[0], 137);
            check("rr accept spacing b", gcyc[3] - gcyc[2], 137);
        end
        check("rr n_ss gap >= 4", 32'(last_high >= 4), 1);
        check("rr resp count", resp_cnt, 4);
        check("rr last resp owner", 32'(last_resp), 2);

        // Single transactions from the table
        for (int i = 0; i < NV; i++) run_vec(i);

        // Client 1 raises then withdraws valid during a client 0 frame
        miso_word = 16'h1234;
        r0 = resp_cnt;
        g0 = glog.size();
        issue(0, 1'b1, 5'h05, 8'h77, ok);
        check("wd accept c0", 32'(ok), 1);
        repeat (10) @(negedge clk_in);
        req_valid_in[1] = 1'b1;
        repeat (40) @(negedge clk_in);
        req_valid_in[1] = 1'b0;
        wait_done(r0 + 1, ok);
        check("wd completed", 32'(ok), 1);
        repeat (20) @(negedge clk_in);
        check("wd grant count", glog.size() - g0, 1);
        check("wd resp count", resp_cnt - r0, 1);
        check("wd resp owner", 32'(last_resp), 1);
        // last_grant must still be client 0, so a tie now goes to client 1
        req_valid_in = 2'b11;
        for (int k = 0; k < 400 && glog.size() < g0 + 2; k++) @(negedge clk_in);
        req_valid_in = 2'b00;
        check("wd tie winner", (glog.size() > g0 + 1) ? glog[g0 + 1] : -1, 1);
        wait_done(r0 + 2, ok);
        check("wd tie completed", 32'(ok), 1);

        // Reset during bit 7 of the shift phase
        miso_word = 16'hFFFF;
        r0 = resp_cnt;
        issue(0, 1'b1, 5'h11, 8'h55, ok);
        check("rst accept", 32'(ok), 1);
        for (int k = 0; k < 400 && rise_cnt != 9; k++) @(negedge clk_in);
        check("rst at bit 7", rise_cnt, 9);
        n_rst_in = 1'b0;
        @(negedge clk_in);
        n_rst_in = 1'b1;
        check("rst abort n_ss", 32'(n_ss_out), 1);
        check("rst abort sclk", 32'(sclk_out), 0);
        check("rst abort busy", 32'(busy_out), 0);
        check("rst abort mosi", 32'(mosi_out), 0);
        check("rst abort rdata", 32'(resp_rdata_out), 0);
        repeat (300) @(negedge clk_in);
        check("rst no resp", resp_cnt - r0, 0);
        run_vec(1);

        // CLK_DIV=1, GAP_CYCLES=1 instance
        @(negedge clk_in);
        f_valid = 2'b01;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (f_ready[0]) ok = 1'b1;
            @(negedge clk_in);
        end
        f_valid = 2'b00;
        check("fast accept", 32'(ok), 1);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk_in);
            if (f_resp_cnt >= 1 && !f_busy) ok = 1'b1;
        end
        check("fast completed", 32'(ok), 1);
        check("fast n_ss low cycles", f_last_low, 33);
        check("fast sclk rises", f_rises, 16);
        check("fast sclk min period", f_min_per, 2);
        check("fast sclk max period", f_max_per, 2);
        check("fast resp count", f_resp_cnt, 1);

        check("never both ready", both_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
